// File: rtl/jtcop_obj_pkg.sv
// Shared constants and types for the object-table DMA and the sprite draw engine.
package jtcop_obj_pkg;

    localparam int OBJ_AW               = 10;   // table word address width
    localparam int OBJ_DW               = 16;   // table word width
    localparam int OBJ_WORDS_PER_SPRITE = 4;    // table words describing one sprite

    typedef enum logic {
        IDLE = 1'b0,
        COPY = 1'b1
    } dma_state_t;

endpackage

// File: rtl/jtframe_dual_ram.sv
// Simple dual-port RAM: port A write-only, port B registered read.
// The read register resets to zero so the table output is clean after reset;
// the array itself is never cleared.
module jtframe_dual_ram #(
    parameter int AW = 10,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we_a,
    input  logic [AW-1:0] i_addr_a,
    input  logic [DW-1:0] i_data_a,
    input  logic [AW-1:0] i_addr_b,
    output logic [DW-1:0] o_q_b
);

    logic [DW-1:0] r_mem [0:(1<<AW)-1];
    logic [DW-1:0] r_q_b;

    // Port A: DMA write
    always_ff @(posedge clk) begin
        if (i_we_a) r_mem[i_addr_a] <= i_data_a;
    end

    // Port B: draw-engine read, one clock latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_q_b <= '0;
        else     r_q_b <= r_mem[i_addr_b];
    end

    assign o_q_b = r_q_b;

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object-table DMA with double buffering. A CPU strobe copies the whole CPU
// object RAM into the back bank; the banks swap at the next vblank start so
// the draw engine only ever reads a complete table.
module jtcop_obj_dma
    import jtcop_obj_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          LVBL,
    input  logic          dma_req,
    output logic [AW-1:0] ram_addr,
    input  logic [DW-1:0] ram_dout,
    output logic          busy,
    input  logic [AW-1:0] tbl_addr,
    output logic [DW-1:0] tbl_dout,
    output logic          bank
);

    dma_state_t    r_state, w_state_nxt;
    logic [AW:0]   r_cnt;        // reads issued; MSB marks terminal count
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic          r_req_pend;
    logic          r_swap_pend;
    logic          r_bank;
    logic          r_lvbl_l;

    logic          w_start;
    logic          w_busy;
    logic          w_issue;
    logic          w_done;
    logic          w_vb_start;
    logic          w_swap;
    logic [1:0]    w_we;
    logic [1:0][DW-1:0] w_q;

    // Read address stops at the last word once the counter reaches 2^AW.
    assign ram_addr   = r_cnt[AW] ? {AW{1'b1}} : r_cnt[AW-1:0];
    assign w_issue    = (r_state == COPY) && !r_cnt[AW];
    // Last write is pending when the counter is saturated and the pipe is still full.
    assign w_done     = (r_state == COPY) && r_wr_en && r_cnt[AW];
    assign w_vb_start = r_lvbl_l & ~LVBL;
    assign w_swap     = w_vb_start && r_swap_pend && (r_state == IDLE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state and busy; a pending request restarts the copy from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (dma_req || r_req_pend) begin
                    w_state_nxt = COPY;
                    w_start     = 1'b1;
                end
            end
            COPY: begin
                w_busy = 1'b1;
                if (w_done) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Read counter and the one-clock write pipeline matching the RAM latency
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
        end else begin
            r_wr_en   <= w_issue;
            r_wr_addr <= ram_addr;
            if (w_start)      r_cnt <= '0;
            else if (w_issue) r_cnt <= r_cnt + (AW+1)'(1);
        end
    end

    // Request/swap bookkeeping and bank flip at vblank start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req_pend  <= 1'b0;
            r_swap_pend <= 1'b0;
            r_bank      <= 1'b0;
            r_lvbl_l    <= 1'b0;
        end else begin
            r_lvbl_l <= LVBL;
            if (w_swap) r_bank <= ~r_bank;

            if (w_start)                             r_req_pend <= 1'b0;
            else if ((r_state == COPY) && dma_req)   r_req_pend <= 1'b1;

            // A new copy invalidates a pending swap: the back bank is being overwritten.
            if (w_start)     r_swap_pend <= 1'b0;
            else if (w_done) r_swap_pend <= 1'b1;
            else if (w_swap) r_swap_pend <= 1'b0;
        end
    end

    // Two table banks; only the back bank (index != r_bank) is ever written
    for (genvar g = 0; g < 2; g++) begin : g_bank
        localparam logic SEL = (g == 1);
        assign w_we[g] = r_wr_en & (r_bank != SEL);
        jtframe_dual_ram #(.AW(AW), .DW(DW)) u_ram (
            .clk      (clk),
            .rst      (rst),
            .i_we_a   (w_we[g]),
            .i_addr_a (r_wr_addr),
            .i_data_a (ram_dout),
            .i_addr_b (tbl_addr),
            .o_q_b    (w_q[g])
        );
    end

    assign tbl_dout = r_bank ? w_q[1] : w_q[0];
    assign busy     = w_busy;
    assign bank     = r_bank;

endmodule
